can_status_pack: RTL

CAN_STATUS_PACK -- requirements
Module: can_status_pack

---
 rtl/can_status_pkg.sv | 45 ++++
 rtl/ad_avg256.sv | 50 +++++
 rtl/can_status_pack.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/can_status_pkg.sv
// ---------------------------------------------------------------------------
// can_status_pkg
// Shared constants for the CAN status reporter: default frame identifier,
// data length code, payload field positions, the reporter FSM encoding and
// the payload packing helper.
// ---------------------------------------------------------------------------
package can_status_pkg;

    localparam logic [10:0] STATUS_ID = 11'h181;
    localparam logic [3:0]  TX_DLC    = 4'd8;

    // LSB position of each payload field inside the 64-bit frame (byte0 = [63:56])
    localparam int BYTE0_LSB = 56;
    localparam int AVG_V_LSB = 40;
    localparam int AVG_I_LSB = 24;
    localparam int PULSE_LSB = 8;
    localparam int SHORT_LSB = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Assemble the status payload; averages are zero-extended to 16 bits.
    function automatic logic [63:0] pack_status(
        input logic [1:0]  seq,
        input logic        overrun,
        input logic        occ,
        input logic [3:0]  start,
        input logic [11:0] avg_v,
        input logic [11:0] avg_i,
        input logic [15:0] pulses,
        input logic [7:0]  shorts
    );
        logic [63:0] frame;
        frame                      = 64'd0;
        frame[BYTE0_LSB +: 8]      = {seq, overrun, occ, start};
        frame[AVG_V_LSB +: 16]     = {4'b0000, avg_v};
        frame[AVG_I_LSB +: 16]     = {4'b0000, avg_i};
        frame[PULSE_LSB +: 16]     = pulses;
        frame[SHORT_LSB +: 8]      = shorts;
        return frame;
    endfunction

endpackage

// File: rtl/ad_avg256.sv
// ---------------------------------------------------------------------------
// ad_avg256
// Block averager: accumulates a 12-bit AD code on each strobe and, on the
// strobe that closes a 256-sample block, publishes sum/256 and restarts.
// The closing sample is part of the block it closes.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   sample_en   - AD sample strobe
//   block_end   - this strobe is the 256th of the block (shared counter)
//   ad_code     - 12-bit AD input
//   avg_code    - 12-bit block average (held between blocks)
// ---------------------------------------------------------------------------
module ad_avg256 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_en,
    input  logic        block_end,
    input  logic [11:0] ad_code,
    output logic [11:0] avg_code
);

    logic [19:0] sum_r;
    logic [19:0] sum_next_s;
    logic [11:0] avg_r;

    // Running sum including the current sample; 256 * 4095 fits in 20 bits.
    always_comb begin
        sum_next_s = sum_r + {8'd0, ad_code};
    end

    // Accumulate, and on block end publish sum[19:8] and restart at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= 20'd0;
            avg_r <= 12'd0;
        end else if (sample_en) begin
            if (block_end) begin
                avg_r <= sum_next_s[19:8];
                sum_r <= 20'd0;
            end else begin
                sum_r <= sum_next_s;
            end
        end else begin
            sum_r <= sum_r;
        end
    end

    assign avg_code = avg_r;

endmodule

// File: rtl/can_status_pack.sv
// ---------------------------------------------------------------------------
// can_status_pack
// Periodic CAN status reporter. Averages gap voltage/current over 256-sample
// blocks, counts discharge pulses and short-circuit events, and every
// REPORT_PERIOD cycles offers an 8-byte status frame via a valid/ready
// handshake. A period that ends while a frame is still pending is dropped and
// flagged as overrun in the next frame.
// Ports:
//   clk, rst_n          - 50 MHz clock, asynchronous active-low reset
//   report_en           - periodic reporting enable
//   sample_en           - AD sample strobe; ad_ch1/ad_ch2 gap voltage/current
//   pulse_start         - discharge pulse level (rising edges counted)
//   short_flag          - short-circuit flag (rising edges counted)
//   occ_flag            - closed-loop current control active
//   start_state[3:0]    - Start1..Start4 channel enables
//   tx_valid/tx_ready   - frame handshake to the CAN transmitter
//   tx_id, tx_dlc       - constant identifier and data length
//   tx_data[63:0]       - payload, byte0 in [63:56]
// ---------------------------------------------------------------------------
module can_status_pack #(
    parameter int          REPORT_PERIOD = 50000,
    parameter logic [10:0] STATUS_ID     = can_status_pkg::STATUS_ID
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        report_en,
    input  logic        sample_en,
    input  logic [11:0] ad_ch1,
    input  logic [11:0] ad_ch2,
    input  logic        pulse_start,
    input  logic        short_flag,
    input  logic        occ_flag,
    input  logic [3:0]  start_state,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [10:0] tx_id,
    output logic [3:0]  tx_dlc,
    output logic [63:0] tx_data
);

    import can_status_pkg::*;

    localparam int            TW         = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(REPORT_PERIOD - 1);

    logic [7:0]    samp_cnt_r;
    logic          pulse_d_r;
    logic          short_d_r;
    logic [TW-1:0] timer_r;
    state_t        state_r;
    state_t        state_next_s;
    logic [15:0]   pulse_cnt_r;
    logic [7:0]    short_cnt_r;
    logic [1:0]    seq_r;
    logic          overrun_r;
    logic          tx_valid_r;
    logic [63:0]   tx_data_r;

    logic          block_end_s;
    logic          pulse_rise_s;
    logic          short_rise_s;
    logic          wrap_s;
    logic          snapshot_s;
    logic          accept_s;
    logic          drop_s;
    logic [11:0]   avg_v_s;
    logic [11:0]   avg_i_s;

    // Edge detection, block-end and period-wrap decode.
    always_comb begin
        block_end_s  = (samp_cnt_r == 8'hFF);
        pulse_rise_s = pulse_start & ~pulse_d_r;
        short_rise_s = short_flag & ~short_d_r;
        wrap_s       = report_en & (timer_r == TIMER_LAST);
    end

    ad_avg256 u_avg_v (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .block_end (block_end_s),
        .ad_code   (ad_ch1),
        .avg_code  (avg_v_s)
    );

    ad_avg256 u_avg_i (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .block_end (block_end_s),
        .ad_code   (ad_ch2),
        .avg_code  (avg_i_s)
    );

    // Shared sample counter and input edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt_r <= 8'd0;
            pulse_d_r  <= 1'b0;
            short_d_r  <= 1'b0;
        end else begin
            samp_cnt_r <= sample_en ? (samp_cnt_r + 8'd1) : samp_cnt_r;
            pulse_d_r  <= pulse_start;
            short_d_r  <= short_flag;
        end
    end

    // Report period timer; parked at zero while reporting is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= '0;
        end else if (!report_en || (timer_r == TIMER_LAST)) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end

    // FSM next state: a wrap in IDLE snapshots, a wrap in SEND is dropped.
    always_comb begin
        state_next_s = state_r;
        snapshot_s   = 1'b0;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wrap_s) begin
                    snapshot_s   = 1'b1;
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                accept_s = tx_valid_r & tx_ready;
                drop_s   = wrap_s;
                if (accept_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Saturating event counters; an edge on the snapshot cycle opens the new window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt_r <= 16'd0;
            short_cnt_r <= 8'd0;
        end else if (snapshot_s) begin
            pulse_cnt_r <= {15'd0, pulse_rise_s};
            short_cnt_r <= {7'd0, short_rise_s};
        end else begin
            if (pulse_rise_s && (pulse_cnt_r != 16'hFFFF)) begin
                pulse_cnt_r <= pulse_cnt_r + 16'd1;
            end else begin
                pulse_cnt_r <= pulse_cnt_r;
            end
            if (short_rise_s && (short_cnt_r != 8'hFF)) begin
                short_cnt_r <= short_cnt_r + 8'd1;
            end else begin
                short_cnt_r <= short_cnt_r;
            end
        end
    end

    // Frame register, handshake, sequence number and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 64'd0;
            seq_r      <= 2'd0;
            overrun_r  <= 1'b0;
        end else if (snapshot_s) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= pack_status(seq_r, overrun_r, occ_flag, start_state,
                                      avg_v_s, avg_i_s, pulse_cnt_r, short_cnt_r);
            overrun_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                tx_valid_r <= 1'b0;
                seq_r      <= seq_r + 2'd1;
            end else begin
                tx_valid_r <= tx_valid_r;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
    assign tx_id    = STATUS_ID;
    assign tx_dlc   = TX_DLC;

endmodule
